// File: rtl/riscv_aes_writeback_if.sv
`default_nettype none
// ============================================================================
// riscv_aes_writeback_if : OBI-style data memory write port (req/gnt/rvalid)
// Revision : 1.0
// ============================================================================
interface riscv_aes_writeback_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  data_req;
  logic                  data_gnt;
  logic                  data_rvalid;
  logic                  data_err;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic                  data_we;
  logic [3:0]            data_be;
  logic [DATA_WIDTH-1:0] data_wdata;

  modport master (
    output data_req,
    output data_addr,
    output data_we,
    output data_be,
    output data_wdata,
    input  data_gnt,
    input  data_rvalid,
    input  data_err
  );

  modport slave (
    input  data_req,
    input  data_addr,
    input  data_we,
    input  data_be,
    input  data_wdata,
    output data_gnt,
    output data_rvalid,
    output data_err
  );

endinterface
`default_nettype wire

// File: rtl/riscv_aes_writeback.sv
`default_nettype none
// ============================================================================
// riscv_aes_writeback : stores a finished 128-bit AES block as four word writes
// Revision : 1.0
// ============================================================================
module riscv_aes_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    aes_done_i,
  input  wire logic [4*DATA_WIDTH-1:0] result_i,
  input  wire logic [ADDR_WIDTH-1:0]   wb_addr_i,
  riscv_aes_writeback_if.master        mem,
  output logic                         busy_o,
  output logic                         wb_done_o,
  output logic                         err_o,
  output logic                         overrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                  state_q;
  logic [4*DATA_WIDTH-1:0] buffer_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [ADDR_WIDTH-1:0]   capture_base;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic [1:0]              idx_q;
  logic [1:0]              idx_d;
  logic                    req_q;
  logic                    busy_q;
  logic                    wb_done_q;
  logic                    err_q;
  logic                    overrun_q;

  // Word writes are always word-aligned, so the byte offset is discarded.
  wire unused_addr_lsbs = ^wb_addr_i[1:0];

  assign capture_base = {wb_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign idx_d        = idx_q + 2'd1;
  assign addr_d       = base_q + {{(ADDR_WIDTH-4){1'b0}}, idx_d, 2'b00};

  always_comb begin
    wdata_d = buffer_q[DATA_WIDTH-1:0];
    case (idx_d)
      2'd0:    wdata_d = buffer_q[DATA_WIDTH-1:0];
      2'd1:    wdata_d = buffer_q[2*DATA_WIDTH-1:DATA_WIDTH];
      2'd2:    wdata_d = buffer_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
      default: wdata_d = buffer_q[4*DATA_WIDTH-1:3*DATA_WIDTH];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      buffer_q  <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      idx_q     <= 2'd0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      wb_done_q <= 1'b0;
      err_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      wb_done_q <= 1'b0;
      // A block finishing while a write-back is in flight is lost.
      if (aes_done_i && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (aes_done_i) begin
            buffer_q <= result_i;
            base_q   <= capture_base;
            addr_q   <= capture_base;
            wdata_q  <= result_i[DATA_WIDTH-1:0];
            idx_q    <= 2'd0;
            err_q    <= 1'b0;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (mem.data_gnt) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem.data_rvalid) begin
            if (mem.data_err) begin
              err_q <= 1'b1;
            end
            // Errors are recorded but never cut the block short.
            if (idx_q == 2'd3) begin
              wb_done_q <= 1'b1;
              state_q   <= DONE;
            end else begin
              idx_q   <= idx_d;
              addr_q  <= addr_d;
              wdata_q <= wdata_d;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.data_req   = req_q;
  assign mem.data_we    = req_q;
  assign mem.data_be    = {4{req_q}};
  assign mem.data_addr  = addr_q;
  assign mem.data_wdata = wdata_q;
  assign busy_o         = busy_q;
  assign wb_done_o      = wb_done_q;
  assign err_o          = err_q;
  assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_aes_writeback.sv
`default_nettype none
// ============================================================================
// tb_riscv_aes_writeback : randomized scoreboard bench with a stalling memory
// Revision : 1.0
// ============================================================================
module tb_riscv_aes_writeback;

  localparam int AW = 32;
  localparam int DW = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         aes_done_i = 1'b0;
  logic [127:0] result_i = '0;
  logic [31:0]  wb_addr_i = '0;
  logic         busy_o;
  logic         wb_done_o;
  logic         err_o;
  logic         overrun_o;

  always #5 clk = ~clk;

  riscv_aes_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  riscv_aes_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .aes_done_i (aes_done_i),
    .result_i   (result_i),
    .wb_addr_i  (wb_addr_i),
    .mem        (mem_if.master),
    .busy_o     (busy_o),
    .wb_done_o  (wb_done_o),
    .err_o      (err_o),
    .overrun_o  (overrun_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    longint cyc;
    bit     err;
  } dn_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     done_cnt = 0;
  wr_t    wq[$];
  dn_t    dq[$];
  int     gstall_tab[4];
  int     rwait_tab[4];
  bit     err_tab[4];
  int     mem_w = 0;
  bit     spur = 1'b0;
  bit     model_err = 1'b0;
  bit     last_err = 1'b0;
  bit     exp_overrun = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory slave: per-word grant stalls and response delays come from the tables.
  initial begin
    int gcnt;
    int rcnt;
    bit outst;
    gcnt  = -1;
    rcnt  = 0;
    outst = 1'b0;
    mem_if.data_gnt    = 1'b0;
    mem_if.data_rvalid = 1'b0;
    mem_if.data_err    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_if.data_gnt    = 1'b0;
      mem_if.data_rvalid = 1'b0;
      mem_if.data_err    = 1'b0;
      model_err = model_err | last_err;
      last_err  = 1'b0;
      if (rst) begin
        gcnt      = -1;
        outst     = 1'b0;
        model_err = 1'b0;
      end else if (outst) begin
        if (spur) mem_if.data_gnt = 1'($urandom_range(0, 1));
        if (rcnt == 0) begin
          mem_if.data_rvalid = 1'b1;
          mem_if.data_err    = err_tab[mem_w % 4];
          last_err           = err_tab[mem_w % 4];
          outst              = 1'b0;
          mem_w++;
        end else begin
          rcnt--;
        end
      end else if (mem_if.data_req) begin
        if (gcnt < 0) gcnt = gstall_tab[mem_w % 4];
        if (gcnt == 0) begin
          mem_if.data_gnt = 1'b1;
          outst           = 1'b1;
          rcnt            = rwait_tab[mem_w % 4];
          gcnt            = -1;
        end else begin
          gcnt--;
          if (spur && ($urandom_range(0, 3) == 0)) begin
            mem_if.data_rvalid = 1'b1;
            mem_if.data_err    = 1'($urandom_range(0, 1));
          end
        end
      end
    end
  end

  // Monitor: compares every bus cycle and completion against the queues.
  initial begin
    dn_t d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("err_o", err_o, model_err);
        if (mem_if.data_req) begin
          if (wq.size() == 0) begin
            fail("request_without_pending_write");
          end else begin
            chk("addr", mem_if.data_addr, wq[0].addr);
            chk("wdata", mem_if.data_wdata, wq[0].data);
            chk("be", mem_if.data_be, 4'hF);
            chk("we", mem_if.data_we, 1'b1);
            if (mem_if.data_gnt) void'(wq.pop_front());
          end
        end else begin
          chk("be_idle", mem_if.data_be, 4'h0);
          chk("we_idle", mem_if.data_we, 1'b0);
        end
        if (wb_done_o) begin
          if (dq.size() == 0) begin
            fail("unexpected_wb_done");
          end else begin
            d = dq.pop_front();
            chk("done_cycle", cyc, d.cyc);
            chk("done_writes_left", wq.size(), 0);
            chk("done_err", err_o, d.err);
            chk("done_overrun", overrun_o, exp_overrun);
            chk("done_busy", busy_o, 1'b1);
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, mem_if.data_req, 1'b0);
    chk({tag, "_addr"}, mem_if.data_addr, 32'h0);
    chk({tag, "_wdata"}, mem_if.data_wdata, 32'h0);
    chk({tag, "_we"}, mem_if.data_we, 1'b0);
    chk({tag, "_be"}, mem_if.data_be, 4'h0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, wb_done_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
    chk({tag, "_overrun"}, overrun_o, 1'b0);
  endtask

  // Called one time unit after a rising edge; returns in cycle 1 of the block.
  task automatic start_block(input logic [31:0] addr, input logic [127:0] data);
    logic [31:0] base;
    longint      lat;
    bit          e;
    base = {addr[31:2], 2'b00};
    lat  = 9;
    e    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wq.push_back('{base + 32'(4 * k), data[32*k +: 32]});
      lat += longint'(gstall_tab[k] + rwait_tab[k]);
      e |= err_tab[k];
    end
    mem_w = 0;
    dq.push_back('{cyc + lat, e});
    aes_done_i = 1'b1;
    result_i   = data;
    wb_addr_i  = addr;
    @(posedge clk);
    #1;
    aes_done_i = 1'b0;
    result_i   = {$urandom, $urandom, $urandom, $urandom};
    wb_addr_i  = $urandom;
    model_err  = 1'b0;
    chk("capture_busy", busy_o, 1'b1);
    chk("capture_req", mem_if.data_req, 1'b1);
    chk("capture_err_clear", err_o, 1'b0);
  endtask

  task automatic run_block(input logic [31:0] addr, input logic [127:0] data,
                           input int ovr_at, input int gap);
    int start;
    int t;
    start = done_cnt;
    start_block(addr, data);
    if (ovr_at > 0) begin
      repeat (ovr_at - 1) begin
        @(posedge clk);
        #1;
      end
      aes_done_i  = 1'b1;
      result_i    = {$urandom, $urandom, $urandom, $urandom};
      wb_addr_i   = $urandom;
      exp_overrun = 1'b1;
      @(posedge clk);
      #1;
      aes_done_i = 1'b0;
    end
    t = 0;
    while ((done_cnt == start) && (t < 400)) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (done_cnt == start) fail("wb_done_timeout");
    else chk("idle_after_done", busy_o, 1'b0);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_tables();
    for (int k = 0; k < 4; k++) begin
      gstall_tab[k] = 0;
      rwait_tab[k]  = 0;
      err_tab[k]    = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  a;
    logic [127:0] d;
    int           ovr;
    clear_tables();
    #12;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic write at full speed.
    run_block(32'h1000_0000, 128'h33333333_22222222_11111111_00000000, 0, 0);

    // Three grant-wait cycles on word 1, issued back to back.
    gstall_tab[1] = 3;
    run_block(32'h2000_0010, {$urandom, $urandom, $urandom, $urandom}, 0, 1);
    clear_tables();

    // Address wrap and alignment.
    run_block(32'hFFFF_FFFB, {$urandom, $urandom, $urandom, $urandom}, 0, 0);

    // Error on word 2; the following capture must clear it.
    err_tab[2] = 1'b1;
    run_block(32'h0000_4000, {$urandom, $urandom, $urandom, $urandom}, 0, 2);
    clear_tables();

    // Overrun during WAIT of word 1.
    run_block(32'h0000_8000, {$urandom, $urandom, $urandom, $urandom}, 4, 3);
    chk("overrun_sticky", overrun_o, 1'b1);

    // Reset while word 2 is being requested.
    gstall_tab[2] = 5;
    start_block(32'h0000_C000, {$urandom, $urandom, $urandom, $urandom});
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_req", mem_if.data_req, 1'b1);
    #2;
    rst         = 1'b1;
    model_err   = 1'b0;
    last_err    = 1'b0;
    exp_overrun = 1'b0;
    wq.delete();
    dq.delete();
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_tables();
    run_block(32'h0000_D004, {$urandom, $urandom, $urandom, $urandom}, 0, 1);

    // Randomized blocks.
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        gstall_tab[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        rwait_tab[k]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        err_tab[k]    = ($urandom_range(0, 5) == 0);
      end
      spur = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      d    = {$urandom, $urandom, $urandom, $urandom};
      ovr  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_block(a, d, ovr, int'($urandom_range(0, 2)));
    end
    spur = 1'b0;

    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("final_write_queue_empty", wq.size(), 0);
    chk("final_done_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
